// File: rtl/lsu.sv
// Load/store unit: turns execute-stage load/store requests into one single-beat
// req/gnt/rvalid bus transaction and writes aligned, extended load data back.
module lsu #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mem_load_en,
  input  logic [XLEN-1:0] mem_load_addr,
  input  logic [4:0]      mem_load_regs_addr,
  input  logic            mem_store_en,
  input  logic [XLEN-1:0] mem_store_addr,
  input  logic [XLEN-1:0] mem_store_data,
  input  logic [2:0]      mem_funct3,
  output logic            stall,
  output logic            bus_req,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [3:0]      bus_be,
  output logic [XLEN-1:0] bus_wdata,
  input  logic            bus_gnt,
  input  logic            bus_rvalid,
  input  logic [XLEN-1:0] bus_rdata,
  output logic            regs_write_en,
  output logic [4:0]      regs_write_addr,
  output logic [XLEN-1:0] regs_write_data,
  output logic            misaligned_err,
  output logic            bus_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t          state, state_next;
  logic            req_present, misaligned, accept, timeout_hit, do_abort, abort_q;
  logic [XLEN-1:0] sel_addr, wdata_sel, load_ext;
  logic [1:0]      off, off_q;
  logic [3:0]      be_sel;
  logic [2:0]      funct3_q;
  logic [CW-1:0]   cnt;
  logic [7:0]      byte_val;
  logic [15:0]     half_val;

  // Load wins when both requests are present; the store is simply ignored.
  assign req_present = mem_load_en | mem_store_en;
  assign sel_addr    = mem_load_en ? mem_load_addr : mem_store_addr;
  assign off         = sel_addr[1:0];
  assign accept      = (state == IDLE) && req_present && !misaligned;

  always_comb begin
    misaligned = 1'b0;
    case (mem_funct3[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = off[0];
      default: misaligned = (off != 2'b00);
    endcase
  end

  always_comb begin
    be_sel    = 4'b1111;
    wdata_sel = mem_store_data;
    case (mem_funct3[1:0])
      2'b00: begin
        be_sel    = 4'b0001 << off;
        wdata_sel = {(XLEN/8){mem_store_data[7:0]}};
      end
      2'b01: begin
        be_sel    = 4'b0011 << off;
        wdata_sel = {(XLEN/16){mem_store_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign byte_val = bus_rdata[{off_q, 3'b000} +: 8];
  assign half_val = bus_rdata[{off_q[1], 4'b0000} +: 16];

  always_comb begin
    load_ext = bus_rdata;
    case (funct3_q)
      3'b000:  load_ext = {{(XLEN-8){byte_val[7]}}, byte_val};
      3'b001:  load_ext = {{(XLEN-16){half_val[15]}}, half_val};
      3'b100:  load_ext = {{(XLEN-8){1'b0}}, byte_val};
      3'b101:  load_ext = {{(XLEN-16){1'b0}}, half_val};
      default: load_ext = bus_rdata;
    endcase
  end

  assign timeout_hit = (TIMEOUT > 0) && (cnt == CNT_LAST) &&
                       ((state == REQ) || (state == WAIT_R));

  // A store that is granted completes even on the last allowed cycle; a load
  // still needing its read data is aborted instead.
  always_comb begin
    state_next = state;
    do_abort   = 1'b0;
    case (state)
      IDLE:   if (accept) state_next = REQ;
      REQ: begin
        if (bus_gnt && bus_we) state_next = DONE;
        else if (timeout_hit) begin
          state_next = DONE;
          do_abort   = 1'b1;
        end else if (bus_gnt) state_next = WAIT_R;
      end
      WAIT_R: begin
        if (bus_rvalid) state_next = DONE;
        else if (timeout_hit) begin
          state_next = DONE;
          do_abort   = 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_we          <= 1'b0;
      bus_addr        <= '0;
      bus_be          <= 4'b0000;
      bus_wdata       <= '0;
      funct3_q        <= 3'b000;
      off_q           <= 2'b00;
      regs_write_addr <= 5'd0;
      regs_write_data <= '0;
      cnt             <= '0;
      abort_q         <= 1'b0;
      misaligned_err  <= 1'b0;
    end else begin
      misaligned_err <= (state == IDLE) && req_present && misaligned;
      if (accept) begin
        bus_we          <= ~mem_load_en;
        bus_addr        <= {sel_addr[XLEN-1:2], 2'b00};
        bus_be          <= be_sel;
        bus_wdata       <= wdata_sel;
        funct3_q        <= mem_funct3;
        off_q           <= off;
        regs_write_addr <= mem_load_en ? mem_load_regs_addr : 5'd0;
        cnt             <= '0;
        abort_q         <= 1'b0;
      end else begin
        if ((state == REQ) || (state == WAIT_R)) cnt <= cnt + CW'(1);
        if (do_abort) abort_q <= 1'b1;
      end
      if ((state == WAIT_R) && bus_rvalid) regs_write_data <= load_ext;
    end
  end

  // stall is gated by reset so a request held by execute cannot leak through.
  assign stall = rst_n && ((state == REQ) || (state == WAIT_R) || accept);
  assign bus_req       = (state == REQ);
  assign regs_write_en = (state == DONE) && !bus_we && !abort_q && (regs_write_addr != 5'd0);
  assign bus_err       = (state == DONE) && abort_q;

endmodule
